// File: rtl/uart_rxd.sv
// uart_rxd: 8N1 / 8-data-plus-parity serial receiver with a fixed bit period.
// A received byte is presented as {8'h00, byte} with a ready flag and
// per-character parity, framing and overrun status; the CPU consumes it
// with a one-cycle rd_ack pulse.
module uart_rxd #(
    parameter logic [15:0] TIMES = 16'h28B0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    input  logic        parity_en,
    input  logic        parity_kind,
    input  logic        rd_ack,
    output logic [15:0] rx_data,
    output logic        rx_ready,
    output logic        parity_err,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);

    localparam logic [15:0] HALF     = {1'b0, TIMES[15:1]};
    localparam logic [15:0] HALF_M1  = HALF - 16'd1;
    localparam logic [15:0] TIMES_M1 = TIMES - 16'd1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity mismatch: the data ones-count plus the parity bit must have the
    // polarity selected by odd (1 = odd total, 0 = even total).
    function automatic logic parity_bad(input logic [7:0] data,
                                        input logic       pbit,
                                        input logic       odd);
        return (((^data) ^ pbit) != odd);
    endfunction

    // Synchronizer and reset-qualification
    logic       sync1_r;
    logic       rxd_sync_r;
    logic [1:0] vld_r;

    // Frame engine state
    state_t     state_r,   state_s;
    logic [15:0] cnt_r,    cnt_s;
    logic [2:0] bit_idx_r, bit_idx_s;
    logic [7:0] shreg_r,   shreg_s;
    logic       armed_r,   armed_s;
    logic       pen_r,     pen_s;
    logic       pkind_r,   pkind_s;
    logic       perr_r,    perr_s;
    logic       commit_s;

    // Output registers
    logic [7:0] rx_data_r,    rx_data_s;
    logic       rx_ready_r,   rx_ready_s;
    logic       parity_err_r, parity_err_s;
    logic       frame_err_r,  frame_err_s;
    logic       overrun_r,    overrun_s;
    logic       busy_r,       busy_s;

    // Two-flop synchronizer for rxd; vld_r marks when rxd_sync_r holds a real
    // line sample rather than its reset value, so a line held low across
    // reset release can never arm the start detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r    <= 1'b1;
            rxd_sync_r <= 1'b1;
            vld_r      <= 2'b00;
        end else begin
            sync1_r    <= rxd;
            rxd_sync_r <= sync1_r;
            vld_r      <= {vld_r[0], 1'b1};
        end
    end

    // Next-state and datapath logic of the receive FSM.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        bit_idx_s = bit_idx_r;
        shreg_s   = shreg_r;
        armed_s   = armed_r;
        pen_s     = pen_r;
        pkind_s   = pkind_r;
        perr_s    = perr_r;
        commit_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_s = 16'd0;
                if (rxd_sync_r && vld_r[1]) begin
                    armed_s = 1'b1;
                end else begin
                    armed_s = armed_r;
                end
                if (armed_r && !rxd_sync_r) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == HALF_M1) begin
                    cnt_s = 16'd0;
                    if (rxd_sync_r) begin
                        state_s = ST_IDLE;
                    end else begin
                        pen_s     = parity_en;
                        pkind_s   = parity_kind;
                        bit_idx_s = 3'd0;
                        perr_s    = 1'b0;
                        state_s   = ST_DATA;
                    end
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_r == TIMES_M1) begin
                    cnt_s     = 16'd0;
                    shreg_s   = {rxd_sync_r, shreg_r[7:1]};
                    bit_idx_s = bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) begin
                        state_s = pen_r ? ST_PARITY : ST_STOP;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            ST_PARITY: begin
                if (cnt_r == TIMES_M1) begin
                    cnt_s   = 16'd0;
                    perr_s  = parity_bad(shreg_r, rxd_sync_r, pkind_r);
                    state_s = ST_STOP;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt_r == TIMES_M1) begin
                    cnt_s    = 16'd0;
                    commit_s = 1'b1;
                    state_s  = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            default: begin
                cnt_s   = 16'd0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output update: a commit overrides rd_ack for rx_ready; rd_ack in the
    // commit cycle suppresses overrun.
    always_comb begin
        rx_data_s    = rx_data_r;
        rx_ready_s   = rx_ready_r;
        parity_err_s = parity_err_r;
        frame_err_s  = frame_err_r;
        overrun_s    = overrun_r;
        busy_s       = (state_s != ST_IDLE);
        if (commit_s) begin
            rx_data_s    = shreg_r;
            parity_err_s = pen_r ? perr_r : 1'b0;
            frame_err_s  = ~rxd_sync_r;
            rx_ready_s   = 1'b1;
            if (rd_ack) begin
                overrun_s = 1'b0;
            end else if (rx_ready_r) begin
                overrun_s = 1'b1;
            end else begin
                overrun_s = overrun_r;
            end
        end else if (rd_ack) begin
            rx_ready_s = 1'b0;
            overrun_s  = 1'b0;
        end else begin
            rx_ready_s = rx_ready_r;
            overrun_s  = overrun_r;
        end
    end

    // FSM, bit timer and frame datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 16'd0;
            bit_idx_r <= 3'd0;
            shreg_r   <= 8'h00;
            armed_r   <= 1'b0;
            pen_r     <= 1'b0;
            pkind_r   <= 1'b0;
            perr_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bit_idx_r <= bit_idx_s;
            shreg_r   <= shreg_s;
            armed_r   <= armed_s;
            pen_r     <= pen_s;
            pkind_r   <= pkind_s;
            perr_r    <= perr_s;
        end
    end

    // Registered status/data outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data_r    <= 8'h00;
            rx_ready_r   <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            rx_data_r    <= rx_data_s;
            rx_ready_r   <= rx_ready_s;
            parity_err_r <= parity_err_s;
            frame_err_r  <= frame_err_s;
            overrun_r    <= overrun_s;
            busy_r       <= busy_s;
        end
    end

    assign rx_data    = {8'h00, rx_data_r};
    assign rx_ready   = rx_ready_r;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;
    assign overrun    = overrun_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_uart_rxd.sv
// tb_uart_rxd: table-driven vectors plus hand-written corner sequences for
// uart_rxd at TIMES=16, with a scoreboard queue of expected characters.
module tb_uart_rxd;

    localparam logic [15:0] TIMES = 16'd16;
    localparam int T    = 16;
    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        rxd;
    logic        parity_en;
    logic        parity_kind;
    logic        rd_ack;
    logic [15:0] rx_data;
    logic        rx_ready;
    logic        parity_err;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    uart_rxd #(.TIMES(TIMES)) dut (
        .clk(clk), .rst(rst), .rxd(rxd),
        .parity_en(parity_en), .parity_kind(parity_kind), .rd_ack(rd_ack),
        .rx_data(rx_data), .rx_ready(rx_ready), .parity_err(parity_err),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        pen;
        logic        pkind;
        logic        pbit;
        logic        stop;
        logic        flip;
        logic [15:0] exp_data;
        logic        exp_perr;
        logic        exp_ferr;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic        perr;
        logic        ferr;
        logic        ovr;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[7];
    int   n_pass  = 0;
    int   n_total = 0;
    logic m_ready = 1'b0;
    logic m_ovr   = 1'b0;
    int   lat_np  = 0;
    int   lat_p   = 0;
    int   busy_cnt;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_total++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    // Drive one frame starting at the current negedge; push its expectation.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pkind,
                              input logic pbit, input logic stop, input logic flip,
                              input logic exp_perr, input logic exp_ferr,
                              input logic ack_at_commit);
        exp_t e;
        e.data = {8'h00, d};
        e.perr = exp_perr;
        e.ferr = exp_ferr;
        if (ack_at_commit) m_ovr = 1'b0;
        else if (m_ready)  m_ovr = 1'b1;
        m_ready = 1'b1;
        e.ovr = m_ovr;
        sb_q.push_back(e);
        parity_en   = pen;
        parity_kind = pkind;
        rxd = 1'b0;
        repeat (T) @(negedge clk);
        if (flip) begin
            parity_en   = ~pen;
            parity_kind = ~pkind;
        end
        for (int k = 0; k < 8; k++) begin
            rxd = d[k];
            repeat (T) @(negedge clk);
        end
        if (pen) begin
            rxd = pbit;
            repeat (T) @(negedge clk);
        end
        if (stop) begin
            rxd = 1'b1;
            repeat (T) @(negedge clk);
        end else begin
            // low stop bit, released early so the trailing low reads as a false start
            rxd = 1'b0;
            repeat (T - 4) @(negedge clk);
            rxd = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL %s: scoreboard empty, got rx_data %h", tag, rx_data);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_data"},  rx_data, e.data);
            chk({tag, "_ready"}, {15'd0, rx_ready}, 16'd1);
            chk({tag, "_perr"},  {15'd0, parity_err}, {15'd0, e.perr});
            chk({tag, "_ferr"},  {15'd0, frame_err},  {15'd0, e.ferr});
            chk({tag, "_ovr"},   {15'd0, overrun},    {15'd0, e.ovr});
        end
    endtask

    task automatic ack(input string tag);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        @(negedge clk);
        chk({tag, "_ack_ready"}, {15'd0, rx_ready}, {15'd0, m_ready});
        chk({tag, "_ack_ovr"},   {15'd0, overrun},  {15'd0, m_ovr});
    endtask

    // Negedges from now until rx_ready is seen high; 0 if it never rises.
    task automatic measure_rise(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (rx_ready === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'hA3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h00A3, 1'b1, 1'b0};
        vecs[1] = '{8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h00A3, 1'b0, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h003C, 1'b0, 1'b1};
        vecs[3] = '{8'h96, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0096, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h00FF, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[6] = '{8'h5B, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h005B, 1'b0, 1'b0};

        rst = 1'b1; rxd = 1'b1; parity_en = 1'b0; parity_kind = 1'b0; rd_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data",  rx_data, 16'h0000);
        chk("rst_ready", {15'd0, rx_ready},   16'd0);
        chk("rst_perr",  {15'd0, parity_err}, 16'd0);
        chk("rst_ferr",  {15'd0, frame_err},  16'd0);
        chk("rst_ovr",   {15'd0, overrun},    16'd0);
        chk("rst_busy",  {15'd0, busy},       16'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // 0x55 without parity, with commit latency measurement
        fork
            send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            measure_rise(lat_np);
        join
        chk_range("lat_noparity", lat_np, 2 + HALF + 9 * T - 2, 2 + HALF + 9 * T + 2);
        check_pop("b55");
        ack("b55");

        // 0xA3 odd parity, p=1, with commit latency measurement
        fork
            send_frame(8'hA3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            measure_rise(lat_p);
        join
        chk_range("lat_parity", lat_p, 2 + HALF + 10 * T - 2, 2 + HALF + 10 * T + 2);
        check_pop("bA3odd");
        ack("bA3odd");

        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].data, vecs[i].pen, vecs[i].pkind, vecs[i].pbit,
                       vecs[i].stop, vecs[i].flip, vecs[i].exp_perr, vecs[i].exp_ferr, 1'b0);
            chk($sformatf("vec%0d_tbl", i), rx_data, vecs[i].exp_data);
            check_pop($sformatf("vec%0d", i));
            ack($sformatf("vec%0d", i));
            repeat (2 * T) @(negedge clk);
        end

        // false start: short low pulse
        busy_cnt = 0;
        rxd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        rxd = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        chk_range("false_busy", busy_cnt, 1, HALF + 2);
        chk("false_ready", {15'd0, rx_ready}, 16'd0);
        chk("false_busy_end", {15'd0, busy}, 16'd0);

        // back-to-back with overrun, then ack in the commit cycle
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_pop("b11");
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_pop("b22");
        ack("b22");
        send_frame(8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_pop("b44");
        fork
            send_frame(8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            begin
                repeat (lat_np - 1) @(negedge clk);
                rd_ack = 1'b1;
                @(negedge clk);
                rd_ack = 1'b0;
            end
        join
        check_pop("b33");
        ack("b33");

        // reset in the middle of 0x5A with the line held low through release
        rxd = 1'b0;
        repeat (T) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            rxd = k[0] ? 1'b1 : 1'b0;
            repeat (T) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (T / 2) @(negedge clk);
        rst = 1'b1;
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        chk("mrst_data",  rx_data, 16'h0000);
        chk("mrst_busy",  {15'd0, busy}, 16'd0);
        rst = 1'b0;
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        chk_range("lowrel_busy", busy_cnt, 0, 0);
        chk("lowrel_ready", {15'd0, rx_ready}, 16'd0);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_pop("bC3");
        ack("bC3");

        chk("sb_empty", sb_q.size(), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rxd.md
# uart_rxd

Serial UART receiver for the LC3 I/O subsystem, the receive counterpart of the existing transmit path. Deserializes 8N1 or 8-data-plus-parity frames from the `rxd` line at a fixed bit period of `TIMES` clocks (9600 bps at the system clock). Presents each received byte as a 16-bit keyboard-data word with a ready flag and per-character error status. The CPU consumes the byte with a one-cycle acknowledge.

## Interface
- `TIMES`, default 16'h28B0: clocks per bit period. Must be even and ≥ 8. `HALF` = `TIMES`/2 is derived.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rxd`  in  1  serial input; idles high; asynchronous to `clk`.
- `parity_en`  in  1  1 = a parity bit follows the 8 data bits.
- `parity_kind`  in  1  1 = odd parity, 0 = even parity.
- `rd_ack`  in  1  one-cycle pulse; the CPU has read `rx_data`.
- `rx_data`  out  16  `{8'h00, byte}` of the last committed character.
- `rx_ready`  out  1  an unread character is held.
- `parity_err`  out  1  parity mismatch on the last committed character.
- `frame_err`  out  1  stop bit sampled 0 on the last committed character.
- `overrun`  out  1  a character was committed while `rx_ready` was already 1.
- `busy`  out  1  the FSM is not in IDLE.

## Operation
- `rxd` passes through a 2-flop synchronizer to give `rxd_s`. Both flops reset to 1.
- Internal state:
  - 16-bit bit-timer `cnt`
  - 3-bit `bit_idx`
  - 8-bit shift register, filled LSB-first
  - `armed` flag
  - latched copies of the parity configuration
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE
  - `armed` sets when `rxd_s`=1 and clears on reset.
  - If `armed` and `rxd_s`=0: `cnt`←0, go to START.
- START
  - At `cnt`=`HALF`-1, sample `rxd_s`.
  - Sample 1: false start; return to IDLE, nothing recorded.
  - Sample 0: latch `parity_en`/`parity_kind`, `cnt`←0, `bit_idx`←0, go to DATA.
- DATA
  - At `cnt`=`TIMES`-1: shift `rxd_s` in at the MSB (right shift), `cnt`←0, `bit_idx`++.
  - After the 8th bit, go to PARITY if latched `parity_en`, else go to STOP.
- PARITY
  - At `cnt`=`TIMES`-1, sample `p`.
  - `perr` = ((^byte ^ `p`) != latched `parity_kind`).
  - Go to STOP.
- STOP
  - At `cnt`=`TIMES`-1, sample the stop bit, then commit and go to IDLE.
- Commit (a single cycle):
  - `rx_data`←{8'h00, byte}.
  - `parity_err`←`perr`, or 0 if parity is disabled.
  - `frame_err`←~stop.
  - `overrun` sets if `rx_ready`=1 and `rd_ack`=0 in that cycle.
  - `rx_ready`←1.
  - The data is committed even when an error flag is set.
- `rd_ack` clears `rx_ready` and `overrun`. When commit and `rd_ack` coincide, the commit wins: `rx_ready`=1, no overrun.
- `rd_ack` while `rx_ready`=0 has no effect.
- `parity_en` and `parity_kind` changes mid-frame have no effect until the next START.
- Reset asserted mid-frame:
  - The frame is abandoned.
  - All outputs and the FSM return to reset values.
  - A line held low across reset release is not taken as a start bit, because `armed` requires a high first.

## Timing
- Reset values:
  - `rx_data`=16'h0000
  - `rx_ready`=0
  - `parity_err`=0
  - `frame_err`=0
  - `overrun`=0
  - `busy`=0
  - state IDLE, `cnt`=0, `armed`=0
- Start detect: 2 cycles after `rxd` falls (synchronizer delay).
- Sampling points, counted from start detect:
  - data bit k is sampled at `HALF` + (k+1)·`TIMES` clocks
  - the parity bit and stop bit follow at further `TIMES` intervals
- `rx_ready` rises (±1 cycle) at:
  - 2 + `HALF` + 9·`TIMES` clocks after the `rxd` falling edge, without parity
  - 2 + `HALF` + 10·`TIMES` clocks, with parity
- Error flags and `rx_data` update in the same cycle as `rx_ready`.
- `rx_ready` and `overrun` clear in the cycle after the `rd_ack` edge.
- The FSM is back in IDLE about half a bit before the stop bit ends. Back-to-back frames are received with no idle gap.

## Test plan
Simulate with `TIMES`=16. The bench allows ±2 cycles on sampling and commit timing.
- 0x55, parity off, stop bit 1 → `rx_data`=16'h0055, `rx_ready`=1, `parity_err`=0, `frame_err`=0, `overrun`=0.
- 0xA3 with odd parity:
  - `p`=1 → `rx_data`=16'h00A3, `parity_err`=0.
  - `p`=0 → `rx_data`=16'h00A3, `parity_err`=1.
  - Even parity with `p`=0 → `parity_err`=0.
- 0x3C with stop bit driven 0 → `rx_data`=16'h003C, `frame_err`=1, `rx_ready`=1.
- `rxd` low for 5 clocks (shorter than `HALF`), then high → returns to IDLE, `rx_ready` stays 0, `busy` high for at most `HALF`+2 cycles.
- 0x11 then 0x22 back-to-back with no `rd_ack`:
  - → `rx_data`=16'h0022, `overrun`=1.
  - `rd_ack` pulse → `rx_ready`=0, `overrun`=0.
  - `rd_ack` in the exact commit cycle of a third byte → `rx_ready`=1, `overrun`=0.
- Assert `rst` during DATA of 0x5A with `rxd` held low through release → no commit while low. Then idle high 20 clocks and send 0xC3 → `rx_data`=16'h00C3, no error flags set.
